// File: rtl/mux_scan_ctrl_if.sv
// Handshake/bus bundle between the scan sequencer and its neighbours:
// start/mask request, mux select and return path, and the snapshot channel.
interface mux_scan_ctrl_if;
    logic        i_start;
    logic [30:0] i_chan_mask;
    logic [1:0]  i_mux_out;
    logic        i_snap_ready;
    logic [4:0]  o_sel;
    logic        o_busy;
    logic        o_snap_valid;
    logic [61:0] o_snap_data;
    logic [30:0] o_snap_changed;
    logic [4:0]  o_nz_count;

    modport master (
        output i_start, i_chan_mask, i_mux_out, i_snap_ready,
        input  o_sel, o_busy, o_snap_valid, o_snap_data, o_snap_changed, o_nz_count
    );

    modport slave (
        input  i_start, i_chan_mask, i_mux_out, i_snap_ready,
        output o_sel, o_busy, o_snap_valid, o_snap_data, o_snap_changed, o_nz_count
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 31-channel x 2-bit selector mux. Walks the enabled
// channels in ascending order, holds each select for SETTLE+1 cycles, samples
// the mux output and presents the assembled snapshot with change flags and a
// non-zero channel count on a valid/ready handshake.
module mux_scan_ctrl #(
    parameter int SETTLE = 1
) (
    input  logic           i_clk,
    input  logic           i_reset,
    mux_scan_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t      r_state;
    logic [30:0] r_mask;
    logic [4:0]  r_ch;
    logic [3:0]  r_cnt;
    logic [61:0] r_acc;
    logic [61:0] r_prev;
    logic [4:0]  r_sel;
    logic        r_busy;
    logic        r_valid;
    logic [61:0] r_data;
    logic [30:0] r_changed;
    logic [4:0]  r_nz;

    logic [4:0]  w_first;
    logic        w_first_ok;
    logic [4:0]  w_next;
    logic        w_next_ok;
    logic [61:0] w_samp;
    logic [30:0] w_changed;
    logic [4:0]  w_nz;

    // Select code 5'b11110 is not a mux input; channel 30 lives on 5'b11111.
    function automatic logic [4:0] sel_code(input logic [4:0] ch);
        return (ch == 5'd30) ? 5'd31 : ch;
    endfunction

    // Lowest enabled channel of the incoming mask, and the next enabled
    // channel above the current one in the captured mask.
    always_comb begin
        w_first    = '0;
        w_first_ok = 1'b0;
        w_next     = '0;
        w_next_ok  = 1'b0;
        for (int i = 30; i >= 0; i--) begin
            if (bus.i_chan_mask[i]) begin
                w_first_ok = 1'b1;
                w_first    = 5'(i);
            end
            if (r_mask[i] && (5'(i) > r_ch)) begin
                w_next_ok = 1'b1;
                w_next    = 5'(i);
            end
        end
    end

    // Snapshot including the sample taken this cycle, plus the change flags
    // and non-zero count derived from it so they register alongside valid.
    always_comb begin
        w_samp                   = r_acc;
        w_samp[{r_ch, 1'b0} +: 2] = bus.i_mux_out;
        w_changed                = '0;
        w_nz                     = '0;
        for (int i = 0; i < 31; i++) begin
            w_changed[i] = r_mask[i] && (w_samp[2*i +: 2] != r_prev[2*i +: 2]);
            if (w_samp[2*i +: 2] != 2'b00) w_nz = w_nz + 5'd1;
        end
    end

    // Sequencer: IDLE -> SCAN (per-channel settle/sample) -> DONE (handshake).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= IDLE;
            r_mask    <= '0;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_prev    <= '0;
            r_sel     <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_changed <= '0;
            r_nz      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.i_start) begin
                        r_busy <= 1'b1;
                        r_mask <= bus.i_chan_mask;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                        if (w_first_ok) begin
                            r_state <= SCAN;
                            r_ch    <= w_first;
                            r_sel   <= sel_code(w_first);
                        end else begin
                            r_state <= DONE;
                        end
                    end
                end
                SCAN: begin
                    if (r_cnt == 4'(SETTLE)) begin
                        r_acc <= w_samp;
                        r_cnt <= '0;
                        if (w_next_ok) begin
                            r_ch  <= w_next;
                            r_sel <= sel_code(w_next);
                        end else begin
                            r_state   <= DONE;
                            r_sel     <= '0;
                            r_valid   <= 1'b1;
                            r_data    <= w_samp;
                            r_changed <= w_changed;
                            r_nz      <= w_nz;
                        end
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                DONE: begin
                    // Empty mask arrives here with valid low; publish zeros one cycle later.
                    if (!r_valid) begin
                        r_valid   <= 1'b1;
                        r_data    <= '0;
                        r_changed <= '0;
                        r_nz      <= '0;
                    end else if (bus.i_snap_ready) begin
                        r_prev  <= r_data;
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.o_sel          = r_sel;
    assign bus.o_busy         = r_busy;
    assign bus.o_snap_valid   = r_valid;
    assign bus.o_snap_data    = r_data;
    assign bus.o_snap_changed = r_changed;
    assign bus.o_nz_count     = r_nz;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: directed scans push hand-computed
// snapshots into per-DUT queues; a monitor pops and compares on each rising
// snap_valid. Two instances cover SETTLE=1 and SETTLE=0.
module tb_mux_scan_ctrl;
    typedef struct {
        logic [61:0] d;
        logic [30:0] chg;
        logic [4:0]  nz;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   seen30 = 1'b0;
    exp_t qa[$];
    exp_t qb[$];
    logic [4:0] sel_tr[$];
    logic [1:0] vals [32];

    localparam logic [61:0] D1 = 62'h24E4E4E4E4E4E4E4;
    localparam logic [61:0] D3 = 62'h24E4E4E4E4E4ECE4;
    localparam logic [30:0] C1 = 31'h6EEEEEEE;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mux_scan_ctrl_if ifa();
    mux_scan_ctrl_if ifb();

    mux_scan_ctrl #(.SETTLE(1)) dut_a (.i_clk(clk), .i_reset(rst_a), .bus(ifa.slave));
    mux_scan_ctrl #(.SETTLE(0)) dut_b (.i_clk(clk), .i_reset(rst_b), .bus(ifb.slave));

    // Mux model: select 31 carries channel 30.
    assign ifa.i_mux_out = (ifa.o_sel == 5'd31) ? vals[30] : vals[ifa.o_sel];
    assign ifb.i_mux_out = (ifb.o_sel == 5'd31) ? vals[30] : vals[ifb.o_sel];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    function automatic logic [4:0] cur_sel(input bit b);
        return b ? ifb.o_sel : ifa.o_sel;
    endfunction

    function automatic logic cur_valid(input bit b);
        return b ? ifb.o_snap_valid : ifa.o_snap_valid;
    endfunction

    // Monitor: compare on each rising snap_valid against the queue head.
    initial begin
        logic pva, pvb;
        exp_t e;
        pva = 1'b0;
        pvb = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.o_sel == 5'd30) seen30 = 1'b1;
            if (ifa.o_snap_valid && !pva) begin
                if (qa.size() == 0) chk("a_unexpected_snapshot", 1, 0);
                else begin
                    e = qa.pop_front();
                    chk("a_snap_data", 64'(ifa.o_snap_data), 64'(e.d));
                    chk("a_snap_changed", 64'(ifa.o_snap_changed), 64'(e.chg));
                    chk("a_nz_count", 64'(ifa.o_nz_count), 64'(e.nz));
                    chk("a_valid_edge", 64'(cyc), 64'(e.t));
                end
            end
            if (ifb.o_snap_valid && !pvb) begin
                if (qb.size() == 0) chk("b_unexpected_snapshot", 1, 0);
                else begin
                    e = qb.pop_front();
                    chk("b_snap_data", 64'(ifb.o_snap_data), 64'(e.d));
                    chk("b_snap_changed", 64'(ifb.o_snap_changed), 64'(e.chg));
                    chk("b_nz_count", 64'(ifb.o_nz_count), 64'(e.nz));
                    chk("b_valid_edge", 64'(cyc), 64'(e.t));
                end
            end
            pva = ifa.o_snap_valid;
            pvb = ifb.o_snap_valid;
        end
    end

    // Issue a start, push the expectation, then wait (bounded) for valid,
    // recording sel at every negedge from the start edge onward.
    task automatic run_scan(input bit b, input logic [30:0] mask, input int n_en,
                            input logic [61:0] d, input logic [30:0] chg, input logic [4:0] nz);
        exp_t e;
        int   s;
        int   i;
        s = b ? 0 : 1;
        @(negedge clk);
        if (b) begin ifb.i_chan_mask = mask; ifb.i_start = 1'b1; end
        else   begin ifa.i_chan_mask = mask; ifa.i_start = 1'b1; end
        e.d = d; e.chg = chg; e.nz = nz;
        e.t = cyc + 1 + ((n_en == 0) ? 1 : n_en * (s + 1));
        if (b) qb.push_back(e); else qa.push_back(e);
        sel_tr.delete();
        @(negedge clk);
        // Mask changes after capture must not disturb the scan.
        if (b) begin ifb.i_start = 1'b0; ifb.i_chan_mask = ~mask; end
        else   begin ifa.i_start = 1'b0; ifa.i_chan_mask = ~mask; end
        sel_tr.push_back(cur_sel(b));
        i = 0;
        while (!cur_valid(b) && i < 300) begin
            @(negedge clk);
            sel_tr.push_back(cur_sel(b));
            i++;
        end
        if (!cur_valid(b)) chk("valid_timeout", 0, 1);
    endtask

    task automatic accept(input bit b);
        if (b) ifb.i_snap_ready = 1'b1; else ifa.i_snap_ready = 1'b1;
        @(negedge clk);
        if (b) ifb.i_snap_ready = 1'b0; else ifa.i_snap_ready = 1'b0;
        chk("accept_busy", 64'(cur_valid(b) | (b ? ifb.o_busy : ifa.o_busy)), 0);
    endtask

    initial begin
        int i;
        for (int k = 0; k < 32; k++) vals[k] = 2'(k % 4);
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.i_start = 1'b0; ifa.i_chan_mask = '0; ifa.i_snap_ready = 1'b0;
        ifb.i_start = 1'b0; ifb.i_chan_mask = '0; ifb.i_snap_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sel", 64'(ifa.o_sel), 0);
        chk("rst_busy_valid", 64'({ifa.o_busy, ifa.o_snap_valid}), 0);
        chk("rst_data", 64'(ifa.o_snap_data), 0);
        chk("rst_changed_nz", 64'({ifa.o_snap_changed, ifa.o_nz_count}), 0);
        rst_a = 1'b0; rst_b = 1'b0;

        // A: full scan, values i mod 4, previous snapshot zero.
        run_scan(0, '1, 31, D1, C1, 5'd23);
        accept(0);
        // B: identical data, no changes.
        run_scan(0, '1, 31, D1, 31'h0, 5'd23);
        accept(0);
        // C: channel 5 flips to 3; hold ready low with a stray start.
        vals[5] = 2'd3;
        run_scan(0, '1, 31, D3, 31'h20, 5'd23);
        for (int k = 0; k < 10; k++) begin
            ifa.i_start = (k == 3);
            @(negedge clk);
            chk("hold_data", 64'(ifa.o_snap_data), 64'(D3));
            chk("hold_busy_valid_sel", 64'({ifa.o_busy, ifa.o_snap_valid, ifa.o_sel}), 64'({1'b1, 1'b1, 5'd0}));
        end
        ifa.i_start = 1'b1;
        accept(0);
        ifa.i_start = 1'b0;
        @(negedge clk);
        chk("start_at_accept_ignored", 64'(ifa.o_busy), 0);

        // F: reset while channel 7 is selected.
        @(negedge clk);
        ifa.i_chan_mask = '1; ifa.i_start = 1'b1;
        @(negedge clk);
        ifa.i_start = 1'b0;
        i = 0;
        while (ifa.o_sel != 5'd7 && i < 100) begin @(negedge clk); i++; end
        chk("reach_ch7", 64'(ifa.o_sel), 7);
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        chk("midrst_sel_busy_valid", 64'({ifa.o_sel, ifa.o_busy, ifa.o_snap_valid}), 0);
        chk("midrst_data", 64'(ifa.o_snap_data), 0);
        chk("midrst_changed_nz", 64'({ifa.o_snap_changed, ifa.o_nz_count}), 0);

        // G: after reset, changes reported against zero, not against D3.
        vals[5] = 2'd1;
        run_scan(0, '1, 31, D1, C1, 5'd23);
        accept(0);

        // D: channels 0 and 30 only.
        run_scan(0, 31'h4000_0001, 2, 62'h2000_0000_0000_0000, 31'h0, 5'd1);
        chk("sel_seq_0", 64'(sel_tr[0]), 0);
        chk("sel_seq_1", 64'(sel_tr[1]), 0);
        chk("sel_seq_2", 64'(sel_tr[2]), 31);
        chk("sel_seq_3", 64'(sel_tr[3]), 31);
        accept(0);

        // E: empty mask.
        run_scan(0, 31'h0, 0, 62'h0, 31'h0, 5'd0);
        accept(0);

        // SETTLE = 0 instance, channels 0..2.
        run_scan(1, 31'h7, 3, 62'h24, 31'h6, 5'd2);
        chk("b_sel_seq_0", 64'(sel_tr[0]), 0);
        chk("b_sel_seq_1", 64'(sel_tr[1]), 1);
        chk("b_sel_seq_2", 64'(sel_tr[2]), 2);
        accept(1);

        repeat (3) @(negedge clk);
        chk("a_queue_drained", 64'(qa.size()), 0);
        chk("b_queue_drained", 64'(qb.size()), 0);
        chk("sel_never_30", 64'(seen30), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Scan sequencer that sits directly upstream of the team's 31-channel, 2-bit-wide selector mux. It drives the mux select, waits a programmable settle time, samples the 2-bit mux output, and assembles one snapshot of all enabled channels. Snapshots are presented on a valid/ready interface, together with per-channel change flags and a count of non-zero channels, for the downstream status logic.

## Interface
- SETTLE, 1, idle cycles per channel between a select change and its sample; legal range 0..15
- clk  input  1  clock; all logic is rising-edge triggered
- reset  input  1  synchronous, active-high reset
- start  input  1  single-cycle request to begin a scan; honoured only in IDLE
- chan_mask  input  31  per-channel enable, bit i = channel i; captured on the accepted start
- mux_out  input  2  output of the selector mux
- sel  output  5  mux select, registered
- busy  output  1  high from the accepted start until the snapshot is accepted
- snap_valid  output  1  snapshot available
- snap_ready  input  1  consumer accepts the snapshot
- snap_data  output  62  channel i value in bits [2i+1:2i]
- snap_changed  output  31  bit i set when channel i differs from the previously accepted snapshot
- nz_count  output  5  number of channels in snap_data with a non-zero value (0..31)

## Operation
- Channel-to-select mapping:
  - channels 0..29 use sel = i.
  - channel 30 uses sel = 5'b11111.
  - 5'b11110 is never driven.
- States: IDLE, SCAN, DONE.
- IDLE: sel = 0 and busy = 0. When start = 1:
  - capture chan_mask and set busy = 1.
  - if the mask is non-zero, go to SCAN at the lowest enabled channel.
  - if the mask is all-zero, go directly to DONE.
- SCAN: for each enabled channel, in ascending order:
  - drive the channel's sel code for exactly SETTLE+1 cycles.
  - sample mux_out into the snapshot at the clock edge that ends the last of those cycles.
  - disabled channels are skipped with no cycles spent.
- After the last enabled channel is sampled, go to DONE.
- Disabled channels report 2'b00 in snap_data.
- DONE:
  - snap_valid = 1.
  - snap_data, snap_changed and nz_count are held stable.
  - sel returns to 0.
- On snap_valid && snap_ready: store snap_data as the previous snapshot, then go to IDLE, clearing snap_valid and busy.
- snap_changed[i] = enabled[i] && (new value != previous accepted value). Disabled channels give 0.
- nz_count counts channels whose 2-bit value is non-zero. Disabled channels count as zero.
- start is ignored in SCAN and DONE, with no queuing.
- chan_mask changes after capture have no effect on the scan in progress.

## Timing
- Reset values:
  - sel = 0, busy = 0, snap_valid = 0, snap_data = 0, snap_changed = 0, nz_count = 0.
  - previous snapshot = 0, state = IDLE.
- Let start be sampled at edge T and N = number of enabled channels (N ≥ 1):
  - from T: busy = 1 and sel = code of the first enabled channel.
  - channel k (0-based) is sampled at edge T + (k+1)(SETTLE+1). The next channel's sel is applied at that same edge.
  - at edge T + N(SETTLE+1): snap_valid = 1, carrying all samples including the last.
- All-zero mask: snap_valid = 1 at T+1, with snap_data = 0, snap_changed = 0 and nz_count = 0.
- Acceptance at edge A (snap_valid && snap_ready): snap_valid = 0 and busy = 0 from A.
  - a start at edge A is ignored, because the state is not yet IDLE.
  - the earliest new start is at A+1.
- snap_ready while snap_valid = 0 has no effect.
- Reset asserted mid-scan or in DONE:
  - all outputs return to their reset values at that edge.
  - the previous snapshot is cleared.
  - the partial snapshot is discarded.
- Change flags and nz_count are registered together with snap_valid, with no extra latency.

## Test plan
- Reset, then start with chan_mask = all ones, SETTLE = 1, and the mux model returning (i mod 4) for channel i:
  - snap_valid rises 62 cycles after start.
  - snap_data[1:0] = 0, [3:2] = 1 and [61:60] = 2 (30 mod 4).
  - nz_count = 23.
  - all snap_changed bits are set except channels with value 0.
- chan_mask = 31'h4000_0001:
  - sel sequence is 0,0 then 31,31.
  - snap_valid rises at T+4.
  - sel never takes the value 30.
- Repeat the first scan with identical data: snap_changed = 0. Flip channel 5 to 3: snap_changed = 31'h20.
- Hold snap_ready = 0 for 10 cycles in DONE and pulse start meanwhile:
  - snap_data stays stable and no new scan starts.
  - after snap_ready = 1, busy falls the same edge.
- All-zero mask: snap_valid at T+1 with all outputs zero. Separately, assert reset mid-scan at channel 7: all outputs return to 0 the next edge, and a subsequent scan reports snap_changed relative to 0.
- SETTLE = 0, chan_mask = 31'h7: sel changes every cycle (0,1,2) and snap_valid rises at T+3.
